// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle shared by the acquisition input and output ports.
// Modport d is the data sink (consumes TDATA, drives TREADY); s is the data source.
interface axi4_stream_if #(
    parameter int  DN = 1,
    parameter type DT = logic [8-1:0]
);
    DT [DN-1:0]    TDATA;
    logic [DN-1:0] TKEEP;
    logic          TLAST;
    logic          TVALID;
    logic          TREADY;

    modport d (input TDATA, TKEEP, TLAST, TVALID, output TREADY);
    modport s (output TDATA, TKEEP, TLAST, TVALID, input TREADY);
endinterface

// File: rtl/axi4_stream_acq.sv
// Trigger-based stream acquisition: forwards pre-trigger and post-trigger samples
// from a free-running input stream into a one-deep output register, marking the last with TLAST.
module axi4_stream_acq #(
    parameter int  DN = 1,
    parameter type DT = logic [8-1:0],
    parameter int  CW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ctl_rst,
    input  logic          ctl_acq,
    input  logic          ctl_stp,
    input  logic          trg,
    input  logic [CW-1:0] cfg_pre,
    input  logic [CW-1:0] cfg_pst,
    output logic          sts_run,
    output logic          sts_trg,
    output logic [CW-1:0] sts_pre,
    output logic [CW-1:0] sts_pst,
    output logic [1:0]    dbg_state,
    axi4_stream_if.d      sti,
    axi4_stream_if.s      sto
);
    typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, ARM = 2'd2, POST = 2'd3} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] pre_q, pre_d, pst_q, pst_d;
    DT [DN-1:0]    tdata_q;
    logic [DN-1:0] tkeep_q;
    logic          tlast_q, tvalid_q;
    logic          load, load_last;
    logic          in_ready, in_xfer, out_xfer;
    logic [CW-1:0] pre_inc, pst_inc;

    // Handshake: a beat moves when VALID and READY are both high at a rising edge;
    // VALID never depends on READY, and the input is ready whenever the output slot is free or draining.
    assign in_ready = ~tvalid_q | sto.TREADY;
    assign in_xfer  = sti.TVALID & in_ready;
    assign out_xfer = tvalid_q & sto.TREADY;
    assign pre_inc  = pre_q + CW'(1);
    assign pst_inc  = pst_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        pst_d     = pst_q;
        load      = 1'b0;
        load_last = 1'b0;
        if (ctl_rst) begin
            state_d = IDLE;
            pre_d   = '0;
            pst_d   = '0;
        end else if (ctl_stp) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (ctl_acq) begin
                    pre_d   = '0;
                    pst_d   = '0;
                    state_d = (cfg_pre != '0) ? PRE : ARM;
                end
                PRE: if (in_xfer) begin
                    load  = 1'b1;
                    pre_d = pre_inc;
                    if (pre_inc == cfg_pre) state_d = ARM;
                end
                ARM: if (in_xfer) begin
                    load = 1'b1;
                    if (trg) begin
                        pst_d = CW'(1);
                        if (cfg_pst <= CW'(1)) begin
                            load_last = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            state_d = POST;
                        end
                    end else if (~&pre_q) begin
                        pre_d = pre_inc;
                    end
                end
                POST: if (in_xfer) begin
                    load  = 1'b1;
                    pst_d = pst_inc;
                    if (pst_inc == cfg_pst) begin
                        load_last = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            pre_q   <= '0;
            pst_q   <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            pst_q   <= pst_d;
        end
    end

    // A held sample survives an abort: only ctl_rst or delivery empties the slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else if (ctl_rst) begin
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else if (load) begin
            tdata_q  <= sti.TDATA;
            tkeep_q  <= sti.TKEEP;
            tlast_q  <= load_last;
            tvalid_q <= 1'b1;
        end else if (out_xfer) begin
            tvalid_q <= 1'b0;
        end
    end

    assign sti.TREADY = in_ready;
    assign sto.TDATA  = tdata_q;
    assign sto.TKEEP  = tkeep_q;
    assign sto.TLAST  = tlast_q;
    assign sto.TVALID = tvalid_q;

    assign sts_run   = (state_q != IDLE);
    assign sts_trg   = (state_q == POST);
    assign sts_pre   = pre_q;
    assign sts_pst   = pst_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_axi4_stream_acq.sv
// Directed bench for axi4_stream_acq: ramp stimulus, expected beats queued per scenario,
// a negedge monitor pops and compares every delivered output beat.
module tb_axi4_stream_acq;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          ctl_rst = 1'b0, ctl_acq = 1'b0, ctl_stp = 1'b0, trg = 1'b0;
  logic [CW-1:0] cfg_pre = '0, cfg_pst = '0;
  logic          sts_run, sts_trg;
  logic [CW-1:0] sts_pre, sts_pst;
  logic [1:0]    dbg_state;

  axi4_stream_if #(.DN(1), .DT(logic [7:0])) sti ();
  axi4_stream_if #(.DN(1), .DT(logic [7:0])) sto ();

  axi4_stream_acq #(.DN(1), .DT(logic [7:0]), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .ctl_rst(ctl_rst), .ctl_acq(ctl_acq), .ctl_stp(ctl_stp),
    .trg(trg), .cfg_pre(cfg_pre), .cfg_pst(cfg_pst), .sts_run(sts_run), .sts_trg(sts_trg),
    .sts_pre(sts_pre), .sts_pst(sts_pst), .dbg_state(dbg_state), .sti(sti), .sto(sto)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  logic       prev_stall = 1'b0;
  logic [8:0] held;
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", sto.TVALID, 1);
        chk("hold_beat", {sto.TLAST, sto.TDATA}, held);
      end
      if (sto.TVALID && !sto.TREADY) begin
        chk("stall_rdy", sti.TREADY, 0);
        prev_stall = 1'b1;
        held = {sto.TLAST, sto.TDATA};
      end else begin
        prev_stall = 1'b0;
      end
      if (sto.TVALID && sto.TREADY) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {sto.TLAST, sto.TDATA}, 9'h1ff);
        end else begin
          chk("beat", {sto.TLAST, sto.TDATA}, exp_q.pop_front());
          chk("tkeep", sto.TKEEP, 1);
        end
      end
    end
  end

  // driver tasks
  task automatic push_range(input int lo, input int hi, input bit last_on_hi);
    for (int v = lo; v <= hi; v++) begin
      logic [7:0] d;
      d = v[7:0];
      exp_q.push_back({(last_on_hi && v == hi), d});
    end
  endtask

  task automatic stream(input int first, input int n, input int trg_a, input int trg_b,
                        input int stp_at, input bit bp);
    int s, sent, cyc;
    logic xfer;
    s = first; sent = 0; cyc = 0;
    while (sent < n && cyc < 500) begin
      sti.TVALID = 1'b1;
      sti.TDATA  = s[7:0];
      sti.TKEEP  = 1'b1;
      sti.TLAST  = s[0];
      trg        = (s == trg_a) || (s == trg_b);
      ctl_acq    = (cyc == 0);
      ctl_stp    = (s == stp_at);
      sto.TREADY = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      @(negedge clk);
      xfer = sti.TREADY;
      @(posedge clk);
      #1;
      if (xfer) begin
        s++;
        sent++;
      end
      cyc++;
    end
    if (sent < n) chk("stream_timeout", sent, n);
    sti.TVALID = 1'b0; trg = 1'b0; ctl_acq = 1'b0; ctl_stp = 1'b0; sto.TREADY = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_status(input string tag, input int pre, input int pst);
    chk({tag, "_pre"}, sts_pre, pre);
    chk({tag, "_pst"}, sts_pst, pst);
    chk({tag, "_run"}, sts_run, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_run", sts_run, 0);
    chk("rst_trg", sts_trg, 0);
    chk("rst_pre", sts_pre, 0);
    chk("rst_pst", sts_pst, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_tvalid", sto.TVALID, 0);
    chk("rst_tlast", sto.TLAST, 0);
    chk("rst_tdata", sto.TDATA, 0);
    chk("rst_tkeep", sto.TKEEP, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sti.TVALID = 1'b0; sti.TDATA = '0; sti.TKEEP = '0; sti.TLAST = 1'b0;
    sto.TREADY = 1'b1;
    #1 rstn = 1'b0;
    #1 chk_reset_vals();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    // basic acquisition: samples 1..12, trigger on 10
    cfg_pre = 4; cfg_pst = 3;
    push_range(1, 12, 1);
    stream(0, 16, 10, -1, -1, 0);
    drain();
    chk_status("basic", 9, 3);

    // trigger during PRE is ignored
    cfg_pre = 4; cfg_pst = 2;
    push_range(21, 27, 1);
    stream(20, 12, 22, 26, -1, 0);
    drain();
    chk_status("pretrg", 5, 2);

    // zero counts: straight to ARM, single trigger sample
    cfg_pre = 0; cfg_pst = 0;
    push_range(41, 41, 1);
    stream(40, 6, 41, -1, -1, 0);
    drain();
    chk_status("zero", 0, 1);

    // backpressure throughout, including POST
    cfg_pre = 2; cfg_pst = 3;
    push_range(61, 67, 1);
    stream(60, 20, 65, -1, -1, 1);
    drain();
    chk_status("bp", 4, 3);

    // abort in POST with sts_pst=2 of 5
    cfg_pre = 1; cfg_pst = 5;
    push_range(81, 83, 0);
    stream(80, 10, 82, -1, 84, 0);
    drain();
    chk_status("abort", 1, 2);

    // reset in the middle of POST
    cfg_pre = 1; cfg_pst = 5;
    push_range(101, 103, 0);
    stream(100, 5, 102, -1, -1, 0);
    sto.TREADY = 1'b0;
    chk("midpost_trg", sts_trg, 1);
    chk("midpost_pst", sts_pst, 3);
    chk("midpost_state", dbg_state, 3);
    #1 rstn = 1'b0;
    #1 chk_reset_vals();
    chk("midpost_left", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    sto.TREADY = 1'b1;
    @(posedge clk); #1;

    // clean restart, cfg_pst=1 ends on the trigger sample
    cfg_pre = 0; cfg_pst = 1;
    push_range(121, 121, 1);
    stream(120, 5, 121, -1, -1, 0);
    drain();
    chk_status("restart", 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
